// File: rtl/cache_arbiter_if.sv
// Line-request bundle between the I/D caches, the arbiter and the cacheline adaptor.
// The arbiter takes the slave view; whatever drives the caches and adaptor takes the master view.
interface cache_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic [ADDR_W-1:0] i_address;
  logic              i_read;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic [ADDR_W-1:0] d_address;
  logic              d_read;
  logic              d_write;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic [ADDR_W-1:0] address_o;
  logic              read_o;
  logic              write_o;
  logic [LINE_W-1:0] line_o;
  logic [LINE_W-1:0] line_i;
  logic              resp_i;

  modport slave (
    input  i_address, i_read, d_address, d_read, d_write, d_wdata, line_i, resp_i,
    output i_rdata, i_resp, d_rdata, d_resp, address_o, read_o, write_o, line_o
  );

  modport master (
    output i_address, i_read, d_address, d_read, d_write, d_wdata, line_i, resp_i,
    input  i_rdata, i_resp, d_rdata, d_resp, address_o, read_o, write_o, line_o
  );
endinterface

// File: rtl/cache_arbiter.sv
// Grants one of I-cache / D-cache line requests at a time to the cacheline adaptor.
// D side wins by default; when both wait, the side not served last goes next.
module cache_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 256,
  parameter int OFFSET_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  cache_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_e;

  state_e            state_q;
  logic              last_d_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] line_q;
  logic              rd_q, wr_q;

  logic d_req, i_req, grant_d, grant_i;

  assign d_req   = bus.d_read | bus.d_write;
  assign i_req   = bus.i_read;
  assign grant_d = d_req & (~i_req | ~last_d_q);
  assign grant_i = i_req & (~d_req |  last_d_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      addr_q   <= '0;
      line_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q  <= D_BUSY;
            addr_q   <= {bus.d_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            line_q   <= bus.d_wdata;
            wr_q     <= bus.d_write;
            rd_q     <= ~bus.d_write;
            last_d_q <= 1'b1;
          end else if (grant_i) begin
            state_q  <= I_BUSY;
            addr_q   <= {bus.i_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            wr_q     <= 1'b0;
            rd_q     <= 1'b1;
            last_d_q <= 1'b0;
          end
        end
        I_BUSY, D_BUSY: begin
          // Latched request is held until the adaptor finishes; inputs are ignored.
          if (bus.resp_i) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.address_o = addr_q;
  assign bus.line_o    = line_q;
  assign bus.read_o    = rd_q;
  assign bus.write_o   = wr_q;

  // Response pulses are combinational off resp_i; reset suppresses a same-cycle resp.
  assign bus.i_resp  = (state_q == I_BUSY) & bus.resp_i & ~rst;
  assign bus.d_resp  = (state_q == D_BUSY) & bus.resp_i & ~rst;
  assign bus.i_rdata = bus.line_i;
  assign bus.d_rdata = bus.line_i;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed table, hand sequences, randomized rounds
// checked against a pending-request / last-served reference model.
module tb_cache_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam logic [31:0] MASK = 32'hFFFF_FFE0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();
  cache_arbiter #(.ADDR_W(AW), .LINE_W(LW), .OFFSET_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    bit          ir;
    logic [31:0] ia;
    bit          dr;
    bit          dw;
    logic [31:0] da;
    logic [255:0] dd;
    int          lat;
    bit          exp_d;
    logic [31:0] exp_addr;
    bit          exp_wr;
    logic [255:0] exp_line;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic clear_inputs();
    bus.i_address = '0; bus.i_read = 1'b0;
    bus.d_address = '0; bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_wdata = '0;
    bus.line_i = '0; bus.resp_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drop_side(input bit d);
    if (d) begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
    else bus.i_read = 1'b0;
  endtask

  // One transaction, entered at a negedge with the DUT idle and requests already driven.
  task automatic txn(input bit exp_d, input logic [31:0] exp_addr, input bit exp_wr,
                     input logic [255:0] exp_line, input int lat,
                     input bit drop_early, input bit drop_after);
    logic [255:0] ln;
    chk("idle_rdwr", {bus.read_o, bus.write_o}, 2'b00);
    @(negedge clk);
    chk("grant_read",  bus.read_o,    !exp_wr);
    chk("grant_write", bus.write_o,   exp_wr);
    chk("grant_addr",  bus.address_o, exp_addr);
    chk("grant_line",  bus.line_o,    exp_line);
    if (drop_early) begin
      drop_side(exp_d);
      if (exp_d) begin bus.d_wdata = ~bus.d_wdata; bus.d_address = ~bus.d_address; end
      else bus.i_address = ~bus.i_address;
    end
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      chk("hold_rdwr",   {bus.read_o, bus.write_o}, {!exp_wr, exp_wr});
      chk("hold_addr",   bus.address_o, exp_addr);
      chk("hold_line",   bus.line_o,    exp_line);
      chk("hold_noresp", {bus.i_resp, bus.d_resp}, 2'b00);
    end
    ln = rand256();
    bus.line_i = ln;
    bus.resp_i = 1'b1;
    #1;
    chk("i_resp",  bus.i_resp,  !exp_d);
    chk("d_resp",  bus.d_resp,  exp_d);
    chk("i_rdata", bus.i_rdata, ln);
    chk("d_rdata", bus.d_rdata, ln);
    @(negedge clk);
    bus.resp_i = 1'b0;
    if (drop_after) drop_side(exp_d);
    #1;
    chk("post_rdwr", {bus.read_o, bus.write_o}, 2'b00);
    chk("post_resp", {bus.i_resp, bus.d_resp}, 2'b00);
  endtask

  initial begin
    logic [255:0] pa, pb, pc, w;
    bit ip, dp, drm, dwm, last_d, serve_d, ewr;
    logic [31:0] ia, da, eaddr;
    logic [255:0] dd, lline;
    int op;

    pa = {8{32'hA5A5_0001}};
    pb = {8{32'h5A5A_0002}};
    pc = {8{32'hC3C3_0003}};
    tbl[0] = '{1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0,         '0, 2, 1'b0, 32'h0000_1220, 1'b0, '0};
    tbl[1] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0040, pa, 1, 1'b1, 32'h8000_0040, 1'b1, pa};
    tbl[2] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_005F, pb, 0, 1'b1, 32'h8000_0040, 1'b1, pb};
    tbl[3] = '{1'b1, 32'h0000_0FFF, 1'b1, 1'b0, 32'h1000_0021, pc, 3, 1'b0, 32'h0000_0FE0, 1'b0, pb};
    tbl[4] = '{1'b1, 32'h0000_0FFF, 1'b1, 1'b0, 32'h1000_0021, pc, 1, 1'b1, 32'h1000_0020, 1'b0, pc};
    tbl[5] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,         pa, 0, 1'b0, 32'hFFFF_FFE0, 1'b0, pc};

    // Reset state
    do_reset();
    #1;
    chk("rst_addr", bus.address_o, 32'h0);
    chk("rst_line", bus.line_o, '0);
    chk("rst_rdwr", {bus.read_o, bus.write_o}, 2'b00);
    chk("rst_resp", {bus.i_resp, bus.d_resp}, 2'b00);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      bus.i_read = tbl[i].ir; bus.i_address = tbl[i].ia;
      bus.d_read = tbl[i].dr; bus.d_write = tbl[i].dw;
      bus.d_address = tbl[i].da; bus.d_wdata = tbl[i].dd;
      txn(tbl[i].exp_d, tbl[i].exp_addr, tbl[i].exp_wr, tbl[i].exp_line, tbl[i].lat, i == 0, 1'b1);
    end
    clear_inputs();

    // Reset in the middle of a D write-back, with resp_i arriving alongside it
    do_reset();
    w = rand256();
    bus.d_write = 1'b1; bus.d_address = 32'h8000_0040; bus.d_wdata = w;
    @(negedge clk);
    chk("mid_write", bus.write_o, 1'b1);
    bus.d_wdata = ~w;
    @(negedge clk);
    chk("mid_line_held", bus.line_o, w);
    rst = 1'b1; bus.resp_i = 1'b1;
    #1;
    chk("rst_no_dresp", bus.d_resp, 1'b0);
    @(negedge clk);
    chk("rst2_addr", bus.address_o, 32'h0);
    chk("rst2_line", bus.line_o, '0);
    chk("rst2_rdwr", {bus.read_o, bus.write_o}, 2'b00);
    chk("rst2_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    rst = 1'b0; bus.d_write = 1'b0;
    @(negedge clk);
    chk("idle_resp_ignored", {bus.i_resp, bus.d_resp, bus.read_o, bus.write_o}, 4'b0000);
    bus.resp_i = 1'b0;

    // Both held continuously from reset: D, I, D, I
    do_reset();
    w = rand256();
    bus.i_read = 1'b1; bus.i_address = 32'h0000_3333;
    bus.d_read = 1'b1; bus.d_address = 32'h4000_0077; bus.d_wdata = w;
    txn(1'b1, 32'h4000_0060, 1'b0, w, 1, 1'b0, 1'b0);
    txn(1'b0, 32'h0000_3320, 1'b0, w, 0, 1'b0, 1'b0);
    txn(1'b1, 32'h4000_0060, 1'b0, w, 2, 1'b0, 1'b0);
    txn(1'b0, 32'h0000_3320, 1'b0, w, 1, 1'b0, 1'b0);
    clear_inputs();

    // Randomized rounds against the pending/last-served model
    do_reset();
    ip = 0; dp = 0; drm = 0; dwm = 0; last_d = 0; lline = '0;
    ia = '0; da = '0; dd = '0;
    for (int r = 0; r < 150; r++) begin
      if (!ip && $urandom_range(0, 1) == 1) begin ip = 1; ia = $urandom; end
      if (!dp && $urandom_range(0, 1) == 1) begin
        dp = 1; da = $urandom; dd = rand256();
        op = $urandom_range(0, 2);
        drm = (op != 1); dwm = (op != 0);
      end
      if (!ip && !dp) begin ip = 1; ia = $urandom; end
      bus.i_read = ip; bus.i_address = ia;
      bus.d_read = dp & drm; bus.d_write = dp & dwm;
      bus.d_address = da; bus.d_wdata = dd;

      serve_d = dp && (!ip || !last_d);
      if (serve_d) begin
        eaddr = da & MASK; ewr = dwm; lline = dd; last_d = 1; dp = 0;
      end else begin
        eaddr = ia & MASK; ewr = 0; last_d = 0; ip = 0;
      end
      txn(serve_d, eaddr, ewr, lline, $urandom_range(0, 3), bit'($urandom_range(0, 1)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
